// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared types and cause codes for the exception sequencer
//
// Holds the sequencer state enum, the cause code constants and the
// handler-vector helper used by exc_ctrl and its interface.
package exc_ctrl_pkg;

    localparam int CAUSE_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        TAKE    = 2'd2,
        HANDLER = 2'd3
    } exc_state_e;

    localparam logic [CAUSE_W-1:0] CAUSE_SYS      = 5'd8;
    localparam logic [CAUSE_W-1:0] CAUSE_ILL      = 5'd10;
    localparam logic [CAUSE_W-1:0] CAUSE_OVF      = 5'd12;
    localparam logic [CAUSE_W-1:0] CAUSE_IRQ_BASE = 5'd16;
    localparam logic [CAUSE_W-1:0] CAUSE_DBL      = 5'd31;

    // Each cause owns an 8-byte slot above the vector base.
    function automatic logic [31:0] exc_vector(input logic [31:0] base,
                                               input logic [CAUSE_W-1:0] cause);
        return base + {24'b0, cause, 3'b000};
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - signal bundle between exc_ctrl and pipeline/irq/status register
//
// master : the sequencer side (exc_ctrl) - consumes requests, drives
//          drain_req/exception/flush/epc/cause/vector.
// slave  : the environment side (pipeline, irq pins, status register).
// Mask-register signals exist only when EXC_CTRL_IRQ_MASK_EN is defined.
interface exc_ctrl_if
    import exc_ctrl_pkg::*;
#(
    parameter int NIRQ = 4
) ();

    logic [NIRQ-1:0]    irq;
    logic               exc_ovf;
    logic               exc_ill;
    logic               exc_sys;
    logic [31:0]        pc_in;
    logic               ie;
    logic               rfe;
    logic               drain_ack;
    logic               drain_req;
    logic               exception;
    logic               flush;
    logic [31:0]        epc;
    logic [CAUSE_W-1:0] cause;
    logic [31:0]        vector;
`ifdef EXC_CTRL_IRQ_MASK_EN
    logic               mask_we;
    logic [NIRQ-1:0]    mask_wdata;
    logic [NIRQ-1:0]    irq_mask;
`endif

    modport master (
        input  irq, exc_ovf, exc_ill, exc_sys, pc_in, ie, rfe, drain_ack,
`ifdef EXC_CTRL_IRQ_MASK_EN
        input  mask_we, mask_wdata,
        output irq_mask,
`endif
        output drain_req, exception, flush, epc, cause, vector
    );

    modport slave (
        output irq, exc_ovf, exc_ill, exc_sys, pc_in, ie, rfe, drain_ack,
`ifdef EXC_CTRL_IRQ_MASK_EN
        output mask_we, mask_wdata,
        input  irq_mask,
`endif
        input  drain_req, exception, flush, epc, cause, vector
    );

endinterface

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority encoder for exceptions and gated IRQs
//
// Ports:
//   exc_ovf_i, exc_ill_i, exc_sys_i : synchronous exception requests
//   irq_i[NIRQ]                     : already-gated interrupt requests
//   valid_o                         : some request is present
//   sync_o                          : the winner is a synchronous exception
//   cause_o[CAUSE_W]                : cause code of the winner
// Priority: ovf > ill > sys > irq[0] > ... > irq[NIRQ-1].
module exc_prio_enc
    import exc_ctrl_pkg::*;
#(
    parameter int NIRQ = 4
) (
    input  logic               exc_ovf_i,
    input  logic               exc_ill_i,
    input  logic               exc_sys_i,
    input  logic [NIRQ-1:0]    irq_i,
    output logic               valid_o,
    output logic               sync_o,
    output logic [CAUSE_W-1:0] cause_o
);

    always_comb begin
        valid_o = 1'b0;
        sync_o  = 1'b0;
        cause_o = '0;
        if (exc_ovf_i) begin
            valid_o = 1'b1;
            sync_o  = 1'b1;
            cause_o = CAUSE_OVF;
        end else if (exc_ill_i) begin
            valid_o = 1'b1;
            sync_o  = 1'b1;
            cause_o = CAUSE_ILL;
        end else if (exc_sys_i) begin
            valid_o = 1'b1;
            sync_o  = 1'b1;
            cause_o = CAUSE_SYS;
        end else begin
            // Scan downward so the lowest-numbered active line is the last write.
            for (int i = NIRQ - 1; i >= 0; i--) begin
                if (irq_i[i]) begin
                    valid_o = 1'b1;
                    cause_o = CAUSE_IRQ_BASE + CAUSE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt entry sequencer in front of the status register
//
// Arbitrates synchronous exceptions and IRQs, drains the pipeline for IRQs,
// issues a one-cycle exception/flush pulse, captures epc/cause and supplies
// the handler vector; tracks rfe back to IDLE.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : exc_ctrl_if.master (irq, exc_*, pc_in, ie, rfe, drain_ack in;
//               drain_req, exception, flush, epc, cause, vector out)
// Optional: EXC_CTRL_IRQ_MASK_EN adds a per-line IRQ mask register
//           (mask_we/mask_wdata in, irq_mask out), reset to all ones.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          NIRQ     = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.master bus
);

    exc_state_e         state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [31:0]        epc_q, epc_d;

    logic [NIRQ-1:0]    irq_eff;
    logic [NIRQ-1:0]    irq_gated;
    logic               enc_valid;
    logic               enc_sync;
    logic [CAUSE_W-1:0] enc_cause;

`ifdef EXC_CTRL_IRQ_MASK_EN
    logic [NIRQ-1:0] mask_q;

    // Arbitration sees the registered mask, so a write lands one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '1;
        end else if (bus.mask_we) begin
            mask_q <= bus.mask_wdata;
        end
    end

    assign irq_eff      = bus.irq & mask_q;
    assign bus.irq_mask = mask_q;
`else
    assign irq_eff = bus.irq;
`endif

    // IRQs only compete from IDLE with interrupts enabled; elsewhere only
    // synchronous exceptions can win the encoder.
    assign irq_gated = (bus.ie && (state_q == IDLE)) ? irq_eff : '0;

    exc_prio_enc #(
        .NIRQ (NIRQ)
    ) u_prio_enc (
        .exc_ovf_i (bus.exc_ovf),
        .exc_ill_i (bus.exc_ill),
        .exc_sys_i (bus.exc_sys),
        .irq_i     (irq_gated),
        .valid_o   (enc_valid),
        .sync_o    (enc_sync),
        .cause_o   (enc_cause)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        case (state_q)
            IDLE: begin
                // rfe here is stray and ignored.
                if (enc_valid && enc_sync) begin
                    cause_d = enc_cause;
                    epc_d   = bus.pc_in;
                    state_d = TAKE;
                end else if (enc_valid) begin
                    cause_d = enc_cause;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Committed: irq/ie dropping does not cancel, only a sync
                // exception can replace the pending cause.
                if (enc_sync) begin
                    cause_d = enc_cause;
                    epc_d   = bus.pc_in;
                    state_d = TAKE;
                end else if (bus.drain_ack) begin
                    epc_d   = bus.pc_in;
                    state_d = TAKE;
                end
            end
            TAKE: begin
                state_d = HANDLER;
            end
            HANDLER: begin
                // A fault inside the handler beats a coincident rfe, mirroring
                // the status register's own priority.
                if (enc_sync) begin
                    cause_d = CAUSE_DBL;
                    state_d = TAKE;
                end else if (bus.rfe) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.drain_req = (state_q == DRAIN);
    assign bus.exception = (state_q == TAKE);
    assign bus.flush     = (state_q == TAKE);
    assign bus.epc       = epc_q;
    assign bus.cause     = cause_q;
    assign bus.vector    = exc_vector(VEC_BASE, cause_q);

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer in front of the status register; owns all entry into the handler.
- Arbitrates synchronous exceptions and external IRQs, drains the pipeline, then issues the one-cycle exception push to the status register.
- Captures EPC and cause code, supplies the handler vector, and tracks the rfe return.
- Sits between the pipeline control, the interrupt pins and the status register (consumes its IE output, drives its exception input).

Parameters:
- NIRQ, 4, number of external interrupt lines (1..8).
- VEC_BASE, 32'h0000_0080, handler vector base address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq  in  NIRQ  level-sensitive interrupt requests.
- exc_ovf  in  1  arithmetic overflow, synchronous exception.
- exc_ill  in  1  illegal instruction, synchronous exception.
- exc_sys  in  1  syscall, synchronous exception.
- pc_in  in  32  PC of the faulting or next instruction.
- ie  in  1  interrupt enable from the status register.
- rfe  in  1  return-from-exception decoded, one-cycle pulse.
- drain_ack  in  1  pipeline drained, safe to redirect.
- drain_req  out  1  request that the pipeline stop issuing and drain.
- exception  out  1  one-cycle push pulse to the status register.
- flush  out  1  one-cycle pipeline flush, coincident with exception.
- epc  out  32  saved PC.
- cause  out  5  latched cause code.
- vector  out  32  handler address, equal to VEC_BASE + {cause,3'b000}.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - drain_req, exception, flush = 0.
  - epc = 0, cause = 0, so vector = VEC_BASE.
- Priority, highest first: exc_ovf (cause 12), exc_ill (10), exc_sys (8), irq[0] (16), ..., irq[NIRQ-1] (16+NIRQ-1). Double fault uses cause 31.
- Gating:
  - Synchronous exceptions are taken regardless of ie.
  - IRQs are taken only when ie=1 and state=IDLE.
- State machine, all transitions on the clk edge:
  - IDLE:
    - A synchronous exception is present: latch cause, latch epc=pc_in, go to TAKE. The next cycle is the pulse; no drain is performed.
    - Otherwise, if ie & |irq: latch cause, go to DRAIN.
    - rfe in IDLE is ignored.
  - DRAIN:
    - drain_req=1 (Moore).
    - Wait for drain_ack. On drain_ack=1, latch epc=pc_in and go to TAKE.
    - The request is committed once DRAIN is entered. Deassertion of irq or ie during DRAIN does not cancel it, and cause is held.
    - A synchronous exception arriving during DRAIN overrides cause and epc and goes straight to TAKE.
  - TAKE:
    - exception=1 and flush=1 for exactly one cycle.
    - Unconditionally go to HANDLER.
  - HANDLER:
    - Wait for rfe. On rfe=1, go to IDLE; a new IRQ can be accepted from the following cycle.
    - Synchronous exception in HANDLER: cause=31, epc unchanged, go to TAKE (nested push).
    - Synchronous exception and rfe in the same cycle: the exception wins and rfe is dropped. This matches the status register, where exception has priority over rfe.
- Latency:
  - Synchronous exception: pulse 1 cycle after detection.
  - IRQ: pulse 1 cycle after drain_ack is sampled.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Reset asserted mid-sequence: state returns to IDLE immediately and any pending request is discarded.

Optional Feature:
- Macro: EXC_CTRL_IRQ_MASK_EN.
- When defined:
  - Adds inputs mask_we (1) and mask_wdata (NIRQ), plus output irq_mask (NIRQ).
  - irq_mask resets to all ones and is written on mask_we.
  - Arbitration uses irq & irq_mask.
  - A write in the same cycle as IDLE arbitration takes effect from the next cycle.
- When undefined:
  - None of these ports exist.
  - All IRQs are unmasked.

Decomposition:
- Package exc_ctrl_pkg holds:
  - State enum: IDLE, DRAIN, TAKE, HANDLER.
  - Cause constants: CAUSE_SYS=8, CAUSE_ILL=10, CAUSE_OVF=12, CAUSE_IRQ_BASE=16, CAUSE_DBL=31.
  - CAUSE_W=5.
- One sub-module: exc_prio_enc, a combinational priority encoder. It maps {exc_ovf, exc_ill, exc_sys, gated irq} to a valid flag and a 5-bit cause.

Test Plan:
- Reset: rst=0 then 1, no requests → state IDLE; drain_req, exception, flush = 0; vector=32'h80 for 10 cycles.
- IRQ path:
  - Stimulus: ie=1, irq=4'b0100, drain_ack raised 3 cycles after drain_req, pc_in=32'h1000 on the ack cycle.
  - Required: one-cycle exception the cycle after ack, cause=18, epc=32'h1000, vector=32'h110.
- Priority and gating:
  - Stimulus: exc_ill=1, irq=4'b0001, ie=0, pc_in=32'h2004.
  - Required: no drain, exception the next cycle, cause=10, epc=32'h2004.
- IE gating: ie=0, irq=4'b1111 for 20 cycles → drain_req and exception stay 0.
- Return and re-entry: in HANDLER, rfe pulse with irq=4'b0001 held → IDLE, then a new DRAIN on the cycle after returning to IDLE; cause=16.
- Collision: in HANDLER, exc_sys=1 and rfe=1 in the same cycle → TAKE, cause=31, epc unchanged, state HANDLER afterwards.
